// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC sequencer and prefetch FIFO reading a combinational program ROM
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   fetch_en                level, 1 = fetching allowed
//   rom_addr / rom_data     ROM word address (pc[17:2]) and same-cycle instruction word
//   instr_valid/instr_ready decode handshake on the FIFO head
//   instr / instr_pc        head instruction word and its byte PC
//   redirect_valid/_pc      branch redirect: flush and restart at redirect_pc (bits [1:0] ignored)
//   halted                  halt detected (only with FETCH_HALT_DETECT_EN, else tied 0)
//
// Optional build macro: FETCH_HALT_DETECT_EN - stop fetching after a BR XZR word is enqueued.
module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [15:0]     rom_addr,
    input  logic [31:0]     rom_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef FETCH_HALT_DETECT_EN
    localparam logic [1:0]  S_HALT    = 2'd2;
    localparam logic [31:0] HALT_WORD = 32'hD600_03E0;
`endif

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;

    // Storage is only ever read through the valid-gated head, so it needs no reset.
    logic [31:0]     fifo_data_q [DEPTH];
    logic [PC_W-1:0] fifo_pc_q   [DEPTH];

    logic push, pop, full, halt_hit;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign rom_addr    = pc_q[17:2];
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : {PC_W{1'b0}};

`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        pop  = instr_valid && instr_ready;
        full = (count_q == FULL_CNT);
        // A full FIFO can still accept a word when the head leaves on the same edge.
        push = (state_q == S_RUN) && (!full || pop) && !redirect_valid;
`ifdef FETCH_HALT_DETECT_EN
        halt_hit = push && (rom_data == HALT_WORD);
`else
        halt_hit = 1'b0;
`endif

        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            // Redirect wins over everything: any same-edge pop/push is dropped.
            state_d  = fetch_en ? S_RUN : S_IDLE;
            pc_d     = {redirect_pc[PC_W-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_d     = pc_q + PC_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                S_IDLE: if (fetch_en) state_d = S_RUN;
                S_RUN: begin
`ifdef FETCH_HALT_DETECT_EN
                    if (halt_hit)      state_d = S_HALT;
                    else if (!fetch_en) state_d = S_IDLE;
`else
                    if (!fetch_en) state_d = S_IDLE;
`endif
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rom_data;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int PC_W = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fetch_en;
    logic [15:0]     rom_addr;
    logic [31:0]     rom_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     word;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   return 32'hF8400140;
            16'd1:   return 32'hF8400161;
            16'd2:   return 32'h8B050083;
            16'd3:   return 32'hCB050086;
            16'd4:   return 32'h91000421;
            16'd5:   return 32'h91000842;
            16'd6:   return 32'h8B010002;
            16'd7:   return 32'hF8000142;
            default: return 32'hD60003E0;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic push_exp(input logic [PC_W-1:0] pc);
        exp_t x;
        x.pc   = pc;
        x.word = rom_word(pc[17:2]);
        exp_q.push_back(x);
    endtask

    // Reset asserted at a negedge, released at the next negedge with the given controls.
    task automatic do_reset(input logic fe, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        rst_n = 1'b1; fetch_en = fe; instr_ready = rdy;
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0 ||
            halted !== 1'b0 || rom_addr !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b instr=%h pc=%h halted=%b rom_addr=%h, expected 0 0 0 0 0",
                     instr_valid, instr, instr_pc, halted, rom_addr);
        end
    endtask

    task automatic test_stream;
        do_reset(1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_latency: valid=%b after first edge, expected 0", instr_valid);
        end
        push_exp(64'h0); push_exp(64'h4); push_exp(64'h8); push_exp(64'hC);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL stream_word%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        do_reset(1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== 32'hF8400140 || instr_pc !== 64'h0) begin
                n_errors++;
                $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h, expected 1 F8400140 0",
                         i, instr_valid, instr, instr_pc);
            end
        end
        n_checks++;
        if (rom_addr !== 16'd2) begin
            n_errors++;
            $display("FAIL stall_rom_addr: got %0d, expected 2", rom_addr);
        end
        instr_ready = 1'b1;
        push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL stall_drain%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
    endtask

    // Continues from test_stall with the FIFO full and ready held high.
    task automatic test_back_to_back;
        push_exp(64'hC); push_exp(64'h10); push_exp(64'h14); push_exp(64'h18); push_exp(64'h1C);
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL b2b_word%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h1B; instr_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'd6) begin
            n_errors++;
            $display("FAIL redirect_flush: valid=%b rom_addr=%0d, expected 0 6", instr_valid, rom_addr);
        end
        exp_q.delete();
        push_exp(64'h18); push_exp(64'h1C);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL redirect_word%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt;
        do_reset(1'b1, 1'b1);
        repeat (2) @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
        for (int i = 0; i <= 8; i++) push_exp(64'(4 * i));
        for (int i = 0; i <= 8; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL halt_word%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (instr_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 16'd9) begin
                n_errors++;
                $display("FAIL halt_frozen%0d: valid=%b halted=%b rom_addr=%0d, expected 0 1 9",
                         i, instr_valid, halted, rom_addr);
            end
            @(negedge clk);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_clear: halted=%b valid=%b, expected 0 0", halted, instr_valid);
        end
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'hF8400140) begin
            n_errors++;
            $display("FAIL halt_refetch: valid=%b pc=%h instr=%h, expected 1 0 F8400140",
                     instr_valid, instr_pc, instr);
        end
`else
        for (int i = 0; i < 12; i++) push_exp(64'(4 * i));
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word || halted !== 1'b0) begin
                n_errors++;
                $display("FAIL nohalt_word%0d: valid=%b pc=%h instr=%h halted=%b, expected pc=%h instr=%h halted=0",
                         i, instr_valid, instr_pc, instr, halted, e.pc, e.word);
            end
            @(negedge clk);
        end
`endif
    endtask

    task automatic test_reset_midrun;
        do_reset(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || rom_addr !== 16'd0 || instr !== 32'h0) begin
            n_errors++;
            $display("FAIL midrun_reset: valid=%b rom_addr=%0d instr=%h, expected 0 0 0",
                     instr_valid, rom_addr, instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_latency: valid=%b, expected 0", instr_valid);
        end
        push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.word) begin
                n_errors++;
                $display("FAIL midrun_word%0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h",
                         i, instr_valid, instr_pc, instr, e.pc, e.word);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_halt();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Active reader for the combinational program ROM (16-bit word address in, 32-bit instruction out, zero-latency read).
- Owns the PC and sequences word reads from the ROM.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from the execute stage and flushes wrong-path words.

Parameters:
- PC_W, 64: width of PC and redirect/instr PC ports (LEGv8 byte address).
- RESET_PC, 0: PC value after reset.
- DEPTH, 2: fetch FIFO entries, power of two, 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fetch_en  in  1  level; 1 = fetch allowed.
- rom_addr  out  16  word address to ROM = pc[17:2].
- rom_data  in  32  ROM instruction word, valid same cycle as rom_addr.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head this cycle.
- instr  out  32  head instruction word.
- instr_pc  out  PC_W  byte PC of head word.
- redirect_valid  in  1  branch taken; flush and restart.
- redirect_pc  in  PC_W  target byte address; bits [1:0] ignored (treated as 0).
- halted  out  1  halt detected (see Optional Feature).

Behaviour:
- Reset (rst_n=0, immediate, no clock needed):
  - pc=RESET_PC, FIFO empty, state=IDLE.
  - instr_valid=0, instr=0, instr_pc=0, halted=0, rom_addr=RESET_PC[17:2].
- rom_addr is always pc[17:2], combinational from the pc register.
- States:
  - IDLE: no push. Edge with fetch_en=1 and no redirect -> RUN.
  - RUN: edge with fetch_en=0 -> IDLE. Optional -> HALT.
  - HALT: no push. Edge with redirect_valid -> RUN.
- Push in RUN at an edge when (count<DEPTH or pop this edge) and redirect_valid=0:
  - FIFO gets {rom_data, pc}.
  - pc<=pc+4.
- Pop at an edge when instr_valid && instr_ready.
  - Full FIFO with pop and push on the same edge: count unchanged, throughput 1 word/cycle.
- FIFO is full (count==DEPTH) with no pop: no push, pc holds, rom_addr holds.
- instr/instr_pc/instr_valid come from the FIFO head, with no combinational path from rom_data.
- Latency: fetch_en rises before edge N -> RUN at N; first push at N+1; instr_valid=1 after N+1.
- Redirect, highest priority, at an edge with redirect_valid=1:
  - FIFO flushed (count=0), pc<={redirect_pc[PC_W-1:2],2'b00}.
  - Concurrent pop and push are discarded.
  - instr_valid=0 the following cycle.
  - State becomes RUN if fetch_en=1, else IDLE; this applies from IDLE, RUN or HALT.
- pc wraps modulo 2^PC_W. rom_addr wraps at 2^16 words without special handling.
- fetch_en dropping mid-run: already-buffered words still drain normally.
- Decode must hold instr_ready independent of instr_valid. instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A pushed word equal to 32'hD60003E0 (BR XZR, the ROM default word) is still enqueued.
  - State -> HALT at that edge; pc<=pc+4 and then frozen.
  - halted=1 registered from HALT state; cleared by redirect or reset.
- Undefined:
  - No HALT state; BR XZR is fetched like any other word.
  - halted tied to 0.

Test Plan:
- Reset, fetch_en=1, instr_ready=1 held, no redirect -> instr_valid=1 from cycle 2. Stream is (pc 0x0, F8400140), (0x4, F8400161), (0x8, 8B050083), (0xC, CB050086), one per cycle.
- fetch_en=1, instr_ready=0 for 6 cycles -> FIFO fills with 2 entries, pc stalls at 0x8, rom_addr=2. instr=F8400140 stays stable. Raise ready -> 0x0, 0x4, 0x8 in order, no gaps or duplicates.
- Steady stream with FIFO full, ready=1 -> one word per cycle, count stays DEPTH.
- Redirect with redirect_pc=0x1B while 2 entries are buffered and ready=1 -> next cycle instr_valid=0. Then (0x18, 8B010002), then (0x1C, F8000142).
- With FETCH_HALT_DETECT_EN: run from reset -> (0x20, D60003E0) delivered, halted=1, rom_addr frozen at 9, no further valid words. Redirect to 0x0 -> halted=0, refetch F8400140.
- Without FETCH_HALT_DETECT_EN, same run -> 0x20, 0x24, ... all D60003E0, halted=0.
- Reset mid-run: rst_n low between edges -> instr_valid=0, rom_addr=0 immediately. After release, fetch resumes from 0x0.
